// File: rtl/remote_cmd_pkg.sv
// Command byte codes, receiver state encoding and decode helpers shared by
// the remote command front end.
package remote_cmd_pkg;

    localparam logic [7:0] CMD_FWD     = 8'h46;
    localparam logic [7:0] CMD_BACK    = 8'h42;
    localparam logic [7:0] CMD_LEFT    = 8'h4C;
    localparam logic [7:0] CMD_RIGHT   = 8'h52;
    localparam logic [7:0] CMD_BRAKE   = 8'h58;
    localparam logic [7:0] CMD_STOP    = 8'h53;
    localparam logic [7:0] CMD_AUTO    = 8'h41;
    localparam logic [7:0] CMD_DANCE   = 8'h44;
    localparam logic [7:0] CMD_LED_OFF = 8'h4F;
    localparam logic [7:0] CMD_HEAD    = 8'h48;
    localparam logic [7:0] CMD_YELLOW  = 8'h59;

    localparam int NUM_PULSE = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic logic is_motion_cmd(input logic [7:0] b);
        case (b)
            CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT, CMD_BRAKE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit qualification at half
// a bit, then centre sampling of 8 data bits and the stop bit.
module uart_rx
    import remote_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    rx_state_t     state_r;
    logic [CW-1:0] clk_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;

    // Synchronizer resets high so leaving reset never mimics a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= serial_in;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state machine with registered byte and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= '0;
                    if (!sync2_r) begin
                        state_r <= START;
                    end
                end
                START: begin
                    if (clk_cnt_r == HALF_LAST) begin
                        clk_cnt_r <= '0;
                        bit_idx_r <= 3'd0;
                        state_r   <= sync2_r ? IDLE : DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (clk_cnt_r == FULL_LAST) begin
                        clk_cnt_r <= '0;
                        shift_r   <= {sync2_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (clk_cnt_r == FULL_LAST) begin
                        clk_cnt_r <= '0;
                        state_r   <= IDLE;
                        if (sync2_r) begin
                            rx_byte  <= shift_r;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/remote_cmd_decoder.sv
// Bluetooth serial command front end: decodes ASCII bytes into held motion
// levels with a link-loss timeout and fixed-width mode/LED pulses.
module remote_cmd_decoder
    import remote_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HOLD_CYCLES  = 20_000_000,
    parameter int PULSE_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       forward,
    output logic       backward,
    output logic       left,
    output logic       right,
    output logic       car_break_signal,
    output logic       auto_mode_signal,
    output logic       dance_mode_signal,
    output logic       LED_shutdown,
    output logic       LED_headlight,
    output logic       LED_yellowflash,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

    logic                 motion_s;
    logic                 expire_s;
    logic [NUM_PULSE-1:0] pulse_load_s;
    logic [HW-1:0]        hold_cnt_r;
    logic [PW-1:0]        pulse_cnt_r [NUM_PULSE];
    logic [NUM_PULSE-1:0] pulse_r;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .serial_in(uart_rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    // Classify the received byte; a motion byte cancels a coincident expiry
    always_comb begin
        motion_s     = 1'b0;
        pulse_load_s = '0;
        if (rx_valid) begin
            motion_s = is_motion_cmd(rx_byte);
            case (rx_byte)
                CMD_AUTO:    pulse_load_s[0] = 1'b1;
                CMD_DANCE:   pulse_load_s[1] = 1'b1;
                CMD_LED_OFF: pulse_load_s[2] = 1'b1;
                CMD_HEAD:    pulse_load_s[3] = 1'b1;
                CMD_YELLOW:  pulse_load_s[4] = 1'b1;
                default:     pulse_load_s    = '0;
            endcase
        end else begin
            motion_s = 1'b0;
        end
        expire_s = (hold_cnt_r == HOLD_ONE) && !motion_s;
    end

    // Held motion/brake levels and the link-loss hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            forward          <= 1'b0;
            backward         <= 1'b0;
            left             <= 1'b0;
            right            <= 1'b0;
            car_break_signal <= 1'b0;
            hold_cnt_r       <= '0;
        end else begin
            if (expire_s) begin
                forward          <= 1'b0;
                backward         <= 1'b0;
                left             <= 1'b0;
                right            <= 1'b0;
                car_break_signal <= 1'b0;
            end
            if (hold_cnt_r != '0) begin
                hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end
            if (rx_valid) begin
                case (rx_byte)
                    CMD_FWD: begin
                        forward          <= 1'b1;
                        backward         <= 1'b0;
                        car_break_signal <= 1'b0;
                        hold_cnt_r       <= HOLD_LOAD;
                    end
                    CMD_BACK: begin
                        backward         <= 1'b1;
                        forward          <= 1'b0;
                        car_break_signal <= 1'b0;
                        hold_cnt_r       <= HOLD_LOAD;
                    end
                    CMD_LEFT: begin
                        left       <= 1'b1;
                        right      <= 1'b0;
                        hold_cnt_r <= HOLD_LOAD;
                    end
                    CMD_RIGHT: begin
                        right      <= 1'b1;
                        left       <= 1'b0;
                        hold_cnt_r <= HOLD_LOAD;
                    end
                    CMD_BRAKE: begin
                        car_break_signal <= 1'b1;
                        forward          <= 1'b0;
                        backward         <= 1'b0;
                        hold_cnt_r       <= HOLD_LOAD;
                    end
                    CMD_STOP: begin
                        forward          <= 1'b0;
                        backward         <= 1'b0;
                        left             <= 1'b0;
                        right            <= 1'b0;
                        car_break_signal <= 1'b0;
                        hold_cnt_r       <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Pulse counters; a reload while active stretches the same pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PULSE; i++) begin
                pulse_cnt_r[i] <= '0;
            end
            pulse_r <= '0;
        end else begin
            for (int i = 0; i < NUM_PULSE; i++) begin
                if (pulse_load_s[i]) begin
                    pulse_cnt_r[i] <= PULSE_LOAD;
                    pulse_r[i]     <= 1'b1;
                end else if (pulse_cnt_r[i] != '0) begin
                    pulse_cnt_r[i] <= pulse_cnt_r[i] - PULSE_ONE;
                    pulse_r[i]     <= (pulse_cnt_r[i] != PULSE_ONE);
                end else begin
                    pulse_r[i] <= 1'b0;
                end
            end
        end
    end

    assign {LED_yellowflash, LED_headlight, LED_shutdown,
            dance_mode_signal, auto_mode_signal} = pulse_r;

endmodule

// File: tb/tb_remote_cmd_decoder.sv
// Bench for remote_cmd_decoder: directed sequences, a vector table and random
// frames, all checked every cycle against a timestamp-based reference model.
module tb_remote_cmd_decoder;

    localparam int CPB   = 16;
    localparam int HOLD  = 2000;
    localparam int PULSE = 100;
    // stop-bit centre sample: 2 sync flops + idle detect + half bit + 9 bits
    localparam int STROBE_OFS  = 3 + CPB / 2 + 9 * CPB;
    localparam int TAIL_STROBE = STROBE_OFS - 9 * CPB;
    localparam int TAIL_DECODE = TAIL_STROBE + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       forward, backward, left, right, car_break_signal;
    logic       auto_mode_signal, dance_mode_signal;
    logic       LED_shutdown, LED_headlight, LED_yellowflash;
    logic [7:0] rx_byte;
    logic       rx_valid, frame_err;
    logic [19:0] dut_vec;

    int   cyc = 0;
    logic rst_q;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    typedef struct {
        int         samp;
        logic [7:0] data;
        logic       ok;
    } ev_t;
    ev_t evq[$];

    logic [4:0] m_held = 5'b00000;
    int         m_deadline = 0;
    bit         m_dl_on = 1'b0;
    int         m_pend [5] = '{0, 0, 0, 0, 0};
    logic [7:0] m_byte = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       ok;
        int         gap;
        logic [9:0] exp_out;
        logic [7:0] exp_byte;
    } vec_t;
    vec_t vec [14];

    remote_cmd_decoder #(
        .CLKS_PER_BIT(CPB),
        .HOLD_CYCLES (HOLD),
        .PULSE_CYCLES(PULSE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_rx          (uart_rx),
        .forward          (forward),
        .backward         (backward),
        .left             (left),
        .right            (right),
        .car_break_signal (car_break_signal),
        .auto_mode_signal (auto_mode_signal),
        .dance_mode_signal(dance_mode_signal),
        .LED_shutdown     (LED_shutdown),
        .LED_headlight    (LED_headlight),
        .LED_yellowflash  (LED_yellowflash),
        .rx_byte          (rx_byte),
        .rx_valid         (rx_valid),
        .frame_err        (frame_err)
    );

    assign dut_vec = {forward, backward, left, right, car_break_signal,
                      auto_mode_signal, dance_mode_signal, LED_shutdown,
                      LED_headlight, LED_yellowflash, rx_valid, frame_err, rx_byte};

    always #5 clk = ~clk;

    // Cycle stamp and reset as seen by the DUT at each edge
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Applies a decoded byte at edge c; returns whether it was a motion command
    function automatic bit model_apply(input logic [7:0] b, input int c);
        bit mot = 1'b1;
        case (b)
            8'h46: begin m_held[4] = 1'b1; m_held[3] = 1'b0; m_held[0] = 1'b0; end
            8'h42: begin m_held[3] = 1'b1; m_held[4] = 1'b0; m_held[0] = 1'b0; end
            8'h4C: begin m_held[2] = 1'b1; m_held[1] = 1'b0; end
            8'h52: begin m_held[1] = 1'b1; m_held[2] = 1'b0; end
            8'h58: begin m_held[0] = 1'b1; m_held[4] = 1'b0; m_held[3] = 1'b0; end
            default: mot = 1'b0;
        endcase
        case (b)
            8'h53: begin m_held = 5'b00000; m_dl_on = 1'b0; end
            8'h41: m_pend[0] = c + PULSE;
            8'h44: m_pend[1] = c + PULSE;
            8'h4F: m_pend[2] = c + PULSE;
            8'h48: m_pend[3] = c + PULSE;
            8'h59: m_pend[4] = c + PULSE;
            default: begin end
        endcase
        if (mot) begin
            m_dl_on    = 1'b1;
            m_deadline = c + HOLD;
        end
        return mot;
    endfunction

    task automatic model_step();
        int         c = cyc;
        logic       sv = 1'b0;
        logic       sf = 1'b0;
        bit         dec = 1'b0;
        bit         mot;
        logic [7:0] db = 8'h00;
        logic [4:0] pl;
        if (rst_q) begin
            m_held  = 5'b00000;
            m_dl_on = 1'b0;
            m_byte  = 8'h00;
            for (int i = 0; i < 5; i++) m_pend[i] = 0;
            evq.delete();
        end else begin
            if (evq.size() > 0 && evq[0].samp == c) begin
                if (evq[0].ok) begin
                    sv = 1'b1;
                    m_byte = evq[0].data;
                end else begin
                    sf = 1'b1;
                end
            end
            if (evq.size() > 0 && evq[0].samp + 1 == c) begin
                dec = evq[0].ok;
                db  = evq[0].data;
                void'(evq.pop_front());
            end
            mot = dec && (db inside {8'h46, 8'h42, 8'h4C, 8'h52, 8'h58});
            if (m_dl_on && c == m_deadline && !mot) begin
                m_held  = 5'b00000;
                m_dl_on = 1'b0;
            end
            if (dec) void'(model_apply(db, c));
        end
        for (int i = 0; i < 5; i++) pl[4-i] = (c < m_pend[i]);
        check("model", {12'h000, dut_vec}, {12'h000, m_held, pl, sv, sf, m_byte});
    endtask

    // Continuous comparison against the reference model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) model_step();
        end
    end

    // Drive one frame starting at a negedge; returns tail cycles into the stop bit
    task automatic send_frame(input logic [7:0] d, input logic ok, input int tail, output int c0);
        c0 = cyc;
        evq.push_back('{samp: c0 + STROBE_OFS, data: d, ok: ok});
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            idle(CPB);
        end
        uart_rx = ok;
        idle(tail);
        uart_rx = 1'b1;
    endtask

    initial begin
        int         c0, c1, g;
        logic [7:0] fb;
        logic [7:0] rb;
        logic       rok;
        logic [7:0] pool [16];

        pool = '{8'h46, 8'h42, 8'h4C, 8'h52, 8'h58, 8'h53, 8'h41, 8'h44,
                 8'h4F, 8'h48, 8'h59, 8'h00, 8'h7A, 8'hFF, 8'h61, 8'h66};
        vec[0]  = '{8'h46, 1'b1, 0,  10'b10000_00000, 8'h46};
        vec[1]  = '{8'h4C, 1'b1, 0,  10'b10100_00000, 8'h4C};
        vec[2]  = '{8'h42, 1'b1, 0,  10'b01100_00000, 8'h42};
        vec[3]  = '{8'h52, 1'b1, 0,  10'b01010_00000, 8'h52};
        vec[4]  = '{8'h58, 1'b1, 0,  10'b00011_00000, 8'h58};
        vec[5]  = '{8'h41, 1'b1, 0,  10'b00011_10000, 8'h41};
        vec[6]  = '{8'h44, 1'b1, 0,  10'b00011_01000, 8'h44};
        vec[7]  = '{8'h4F, 1'b1, 0,  10'b00011_00100, 8'h4F};
        vec[8]  = '{8'h48, 1'b1, 0,  10'b00011_00010, 8'h48};
        vec[9]  = '{8'h59, 1'b1, 0,  10'b00011_00001, 8'h59};
        vec[10] = '{8'h7A, 1'b1, 0,  10'b00011_00000, 8'h7A};
        vec[11] = '{8'h41, 1'b0, 30, 10'b00011_00000, 8'h7A};
        vec[12] = '{8'h53, 1'b1, 0,  10'b00000_00000, 8'h53};
        vec[13] = '{8'h46, 1'b1, 0,  10'b10000_00000, 8'h46};

        rst = 1'b1;
        uart_rx = 1'b1;
        idle(3);
        chk_en = 1'b1;
        idle(2);
        check("reset_state", {12'h000, dut_vec}, 32'h0);
        rst = 1'b0;
        idle(5);

        // forward sets one cycle after the strobe and drops HOLD cycles later
        send_frame(8'h46, 1'b1, TAIL_STROBE, c0);
        check("t1_valid", rx_valid, 1'b1);
        check("t1_byte", rx_byte, 8'h46);
        idle(1);
        check("t1_fwd_on", forward, 1'b1);
        wait_to(c0 + STROBE_OFS + HOLD);
        check("t1_fwd_last", forward, 1'b1);
        idle(1);
        check("t1_fwd_drop", forward, 1'b0);
        idle(10);

        // F, L, then B later: deadline follows the last motion byte
        send_frame(8'h46, 1'b1, CPB, c0);
        send_frame(8'h4C, 1'b1, CPB, c0);
        idle(340);
        send_frame(8'h42, 1'b1, TAIL_DECODE, c1);
        check("t2_dir", {forward, backward, left}, 3'b011);
        wait_to(c1 + STROBE_OFS + HOLD);
        check("t2_hold_last", {backward, left}, 2'b11);
        idle(1);
        check("t2_hold_drop", {backward, left}, 2'b00);
        idle(10);

        // headlight pulse timed from the second 'H'
        send_frame(8'h48, 1'b1, CPB, c0);
        idle(50);
        send_frame(8'h48, 1'b1, TAIL_DECODE, c1);
        check("t3_head_on", LED_headlight, 1'b1);
        wait_to(c1 + STROBE_OFS + PULSE);
        check("t3_head_last", LED_headlight, 1'b1);
        idle(1);
        check("t3_head_off", LED_headlight, 1'b0);
        idle(10);

        // bad stop bit, then a short glitch
        send_frame(8'h41, 1'b0, TAIL_STROBE, c0);
        check("t4_ferr", {frame_err, rx_valid}, 2'b10);
        idle(30);
        check("t4_auto", auto_mode_signal, 1'b0);
        check("t4_byte", rx_byte, 8'h48);
        uart_rx = 1'b0;
        idle(5);
        uart_rx = 1'b1;
        idle(30);
        check("t4_glitch_byte", rx_byte, 8'h48);

        // reset in the middle of a data phase
        fb = 8'h46;
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rx = fb[i];
            idle(CPB);
        end
        rst = 1'b1;
        uart_rx = 1'b1;
        idle(4);
        check("t6_reset", {12'h000, dut_vec}, 32'h0);
        rst = 1'b0;
        idle(20);
        send_frame(8'h52, 1'b1, TAIL_DECODE, c0);
        check("t6_right", {forward, backward, left, right, car_break_signal}, 5'b00010);
        idle(10);

        // motion byte decoded on the very cycle the hold expires
        send_frame(8'h46, 1'b1, CPB, c0);
        wait_to(c0 + HOLD);
        send_frame(8'h4C, 1'b1, TAIL_DECODE, c1);
        check("t7_collide", {forward, left}, 2'b11);
        idle(HOLD + 20);

        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
        for (int i = 0; i < 14; i++) begin
            send_frame(vec[i].data, vec[i].ok, TAIL_DECODE, c0);
            check($sformatf("vec%0d", i),
                  {14'h0000, forward, backward, left, right, car_break_signal,
                   auto_mode_signal, dance_mode_signal, LED_shutdown,
                   LED_headlight, LED_yellowflash, rx_byte},
                  {14'h0000, vec[i].exp_out, vec[i].exp_byte});
            idle(CPB - TAIL_DECODE + vec[i].gap);
        end

        for (int n = 0; n < 80; n++) begin
            rb  = pool[$urandom_range(0, 15)];
            rok = ($urandom_range(0, 9) != 0);
            send_frame(rb, rok, CPB, c0);
            g = rok ? $urandom_range(0, 300) : 20 + $urandom_range(0, 100);
            if ($urandom_range(0, 7) == 0) g = HOLD - 200 + $urandom_range(0, 400);
            idle(g);
        end
        idle(HOLD + 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remote_cmd_decoder.md
# remote_cmd_decoder

Serial command front end for the car. Receives 8N1 UART bytes from the Bluetooth module, decodes single-character ASCII commands, and drives the button-level control inputs of `Car_interface`: motion, brake, mode and LED. Motion commands are held only while the phone keeps sending them, and drop automatically on link loss. Mode and LED commands become fixed-width pulses that `signal_op` can one-pulse.

## Interface
- `CLKS_PER_BIT`, 10416, clk cycles per UART bit (100 MHz / 9600 baud, floor)
- `HOLD_CYCLES`, 20_000_000, motion hold timeout after the last motion byte (200 ms)
- `PULSE_CYCLES`, 2_000_000, width of mode/LED output pulses (20 ms)

Ports:
- `clk` in 1: system clock, single clock domain
- `rst` in 1: synchronous, active-high reset
- `uart_rx` in 1: asynchronous serial line, idle high
- `forward`, `backward`, `left`, `right` out 1 each: held motion levels
- `car_break_signal` out 1: held brake level
- `auto_mode_signal`, `dance_mode_signal` out 1 each: mode pulses
- `LED_shutdown`, `LED_headlight`, `LED_yellowflash` out 1 each: LED pulses
- `rx_byte` out 8: last correctly framed byte
- `rx_valid` out 1: 1-cycle strobe when `rx_byte` updates
- `frame_err` out 1: 1-cycle strobe when the stop bit is bad

## Operation
**Input synchronizer**
- 2-FF synchronizer on `uart_rx`; both stages reset to 1.

**UART receiver FSM**
- States: IDLE, START, DATA, STOP.
- IDLE → START on a synced low.
- START waits `CLKS_PER_BIT/2` cycles, then resamples:
  - low → DATA;
  - high → IDLE (glitch rejected, no strobe).
- DATA samples 8 bits, LSB first, every `CLKS_PER_BIT` cycles at bit centre.
- STOP samples once at bit centre:
  - high → `rx_byte` loaded, `rx_valid` pulses;
  - low → `frame_err` pulses and the byte is discarded.
- STOP always returns to IDLE.

**Command decode** (acts on `rx_valid` only)
- 'F' 0x46: `forward`=1, `backward`=0, `car_break_signal`=0
- 'B' 0x42: `backward`=1, `forward`=0, `car_break_signal`=0
- 'L' 0x4C: `left`=1, `right`=0
- 'R' 0x52: `right`=1, `left`=0
- 'X' 0x58: `car_break_signal`=1, `forward`=`backward`=0
- 'S' 0x53: all five held outputs cleared immediately; hold counter stopped
- 'A' 0x41, 'D' 0x44, 'O' 0x4F, 'H' 0x48, 'Y' 0x59: start the pulse on `auto_mode_signal`, `dance_mode_signal`, `LED_shutdown`, `LED_headlight`, `LED_yellowflash` respectively
- Any other byte: ignored; no output change; hold counter not reloaded.

**Hold counter**
- Reloaded to `HOLD_CYCLES` by F/B/L/R/X.
- Decrements each cycle while nonzero.
- On the transition to 0, all five held outputs clear.

**Pulse counters**
- One counter per pulse output; output = (counter != 0).
- Repeating the same command while its pulse is active reloads the counter, giving one extended pulse.

## Timing
- Reset value of every output is 0, including `rx_byte`=0x00. FSM returns to IDLE; all counters are 0.
- `rx_valid` fires on the cycle after the stop-bit centre sample.
- Decoded outputs change on the cycle after `rx_valid`, i.e. 1-cycle decode latency.
- Same-cycle collision: a motion byte arriving as the hold counter expires wins. Outputs take the new command and the counter reloads.
- Orthogonal axes are independent: F then L yields `forward`=`left`=1.
- `rst` during any frame aborts it with no strobe. The next falling edge after `rst` deasserts starts a fresh frame.
- Back-to-back frames are accepted: a start edge is detected in the first IDLE cycle after STOP.
- A `uart_rx` low shorter than `CLKS_PER_BIT/2` never produces `rx_valid` or `frame_err`.

## Structure
- Package `remote_cmd_pkg` holds:
  - the ASCII command constants (`CMD_FWD`, `CMD_BACK`, `CMD_LEFT`, `CMD_RIGHT`, `CMD_BRAKE`, `CMD_STOP`, `CMD_AUTO`, `CMD_DANCE`, `CMD_LED_OFF`, `CMD_HEAD`, `CMD_YELLOW`);
  - the receiver state enum.
- Sub-module `uart_rx` contains the synchronizer, FSM and bit/sample counters. It exports `rx_byte`, `rx_valid` and `frame_err`.
- The top level holds the decode, hold counter and pulse counters.
- Counter widths are sized with `$clog2` of the parameters.

## Test plan
Bench parameters: `CLKS_PER_BIT`=16, `HOLD_CYCLES`=2000, `PULSE_CYCLES`=100.

1. Send 0x46 → `rx_byte`=0x46 with one `rx_valid` strobe. `forward`=1 one cycle later; it drops exactly 2000 cycles after the reload.
2. Send 'F', 'L', then 'B' 500 cycles later → `backward`=`left`=1 and `forward`=0. The hold deadline moves to 2000 cycles after the 'B' decode.
3. Send 'H' twice, 50 cycles apart → a single `LED_headlight` pulse ending 100 cycles after the second decode.
4. Stop bit driven low on 0x41 → one `frame_err` strobe, no `rx_valid`, `auto_mode_signal` stays 0. A 5-cycle low glitch → no strobe at all.
5. Send 'F' then 'S' → all held outputs are 0 the cycle after the 'S' `rx_valid`. Send 0x7A → no output change.
6. Assert `rst` mid-DATA of 'F' → all outputs 0, no strobe. A following clean 'R' decodes normally (`right`=1).
